// File: rtl/decode_issue_stage_pkg.sv
// Shared definitions for the RV64 decode/issue stage: widths, opcodes,
// ALUOp encodings and the control bundle carried into ID/EX.
package decode_issue_stage_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_issue_stage_imm_gen.sv
// Immediate generator: selects the I/S/B immediate by opcode and
// sign-extends it from instr[31] to XLEN. R-type and unknown give 0.
module imm_gen
    import decode_issue_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign unused_bits = ^instr[19:12];

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        imm = '0;
        unique case (opcode)
            OP_IMM, OP_LOAD:
                imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: decodes the IF/ID instruction, detects load-use hazards and
// loads the ID/EX register with flush > stall > hazard > capture priority.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_ready,
    output logic [REG_ADDR_W-1:0] RS1,
    output logic [REG_ADDR_W-1:0] RS2,
    input  logic [XLEN-1:0]       ReadData1,
    input  logic [XLEN-1:0]       ReadData2,
    input  logic                  ex_stall,
    input  logic                  ex_flush,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            ex_funct,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_MemWrite,
    output logic                  ex_ALUSrc,
    output logic                  ex_MemtoReg,
    output logic                  ex_Branch,
    output logic [1:0]            ex_ALUOp,
    output logic                  ex_illegal,
    output logic [31:0]           stall_count
);

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            funct;
    logic [XLEN-1:0]       imm;
    ctrl_t                 id_ctrl;
    ctrl_t                 ex_ctrl;
    logic                  legal;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  load_use;
    logic                  advance;
    logic                  capture;

    assign opcode = if_instr[6:0];
    assign RS1    = REG_ADDR_W'(if_instr[19:15]);
    assign RS2    = REG_ADDR_W'(if_instr[24:20]);
    assign rd     = REG_ADDR_W'(if_instr[11:7]);
    assign funct  = {if_instr[30], if_instr[14:12]};

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    always_comb begin
        id_ctrl  = CTRL_NOP;
        legal    = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        unique case (opcode)
            OP_R: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_op    = ALUOP_R;
                uses_rs2          = 1'b1;
            end
            OP_IMM: begin
                id_ctrl.reg_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_IMM;
            end
            OP_LOAD: begin
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.alu_op     = ALUOP_MEM;
            end
            OP_STORE: begin
                id_ctrl.mem_write = 1'b1;
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_MEM;
                uses_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = ALUOP_BRANCH;
                uses_rs2       = 1'b1;
            end
            default: begin
                legal    = 1'b0;
                uses_rs1 = 1'b0;
            end
        endcase
        // Writes to x0 are architecturally discarded; also keeps forwarding from matching x0.
        if (rd == '0) id_ctrl.reg_write = 1'b0;
    end

    assign load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && if_valid &&
                      ((uses_rs1 && (ex_rd == RS1)) || (uses_rs2 && (ex_rd == RS2)));

    assign id_ready = ex_flush || (!ex_stall && !load_use);
    assign advance  = !ex_flush && !ex_stall && !load_use;
    assign capture  = advance && if_valid && legal;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_illegal  <= 1'b0;
            stall_count <= '0;
        end else begin
            ex_illegal <= advance && if_valid && !legal;
            if (!ex_flush && !ex_stall && load_use && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
            if (ex_flush || !ex_stall) begin
                if (capture) begin
                    ex_valid    <= 1'b1;
                    ex_ctrl     <= id_ctrl;
                    ex_pc       <= if_pc;
                    ex_rs1_data <= ReadData1;
                    ex_rs2_data <= ReadData2;
                    ex_imm      <= imm;
                    ex_rs1      <= RS1;
                    ex_rs2      <= RS2;
                    ex_rd       <= rd;
                    ex_funct    <= funct;
                end else begin
                    ex_valid    <= 1'b0;
                    ex_ctrl     <= CTRL_NOP;
                    ex_pc       <= '0;
                    ex_rs1_data <= '0;
                    ex_rs2_data <= '0;
                    ex_imm      <= '0;
                    ex_rs1      <= '0;
                    ex_rs2      <= '0;
                    ex_rd       <= '0;
                    ex_funct    <= '0;
                end
            end
        end
    end

    assign ex_RegWrite = ex_ctrl.reg_write;
    assign ex_MemRead  = ex_ctrl.mem_read;
    assign ex_MemWrite = ex_ctrl.mem_write;
    assign ex_ALUSrc   = ex_ctrl.alu_src;
    assign ex_MemtoReg = ex_ctrl.mem_to_reg;
    assign ex_Branch   = ex_ctrl.branch;
    assign ex_ALUOp    = ex_ctrl.alu_op;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: reset, decode classes, load-use
// bubble, x0 loads, stall/flush priority, illegal pulse and async reset.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic [4:0]  RS1, RS2;
    logic [63:0] ReadData1, ReadData2;
    logic        ex_stall, ex_flush;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_MemtoReg, ex_Branch;
    logic [1:0]  ex_ALUOp;
    logic        ex_illegal;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .RS1         (RS1),
        .RS2         (RS2),
        .ReadData1   (ReadData1),
        .ReadData2   (ReadData2),
        .ex_stall    (ex_stall),
        .ex_flush    (ex_flush),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_MemtoReg (ex_MemtoReg),
        .ex_Branch   (ex_Branch),
        .ex_ALUOp    (ex_ALUOp),
        .ex_illegal  (ex_illegal),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                         input logic [63:0] d1, input logic [63:0] d2);
        if_valid  = v;
        if_instr  = instr;
        if_pc     = pc;
        ReadData1 = d1;
        ReadData2 = d2;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
        drive(1'b1, 32'h00700293, 64'h0, 64'h0, 64'h55);
        tick(); tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid: got %0h want 0", ex_valid); end
        n_checks++; if (ex_imm !== 64'h0) begin n_fail++; $display("FAIL rst_ex_imm: got %0h want 0", ex_imm); end
        n_checks++; if (ex_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite: got %0h want 0", ex_RegWrite); end
        n_checks++; if (ex_rd !== 5'd0) begin n_fail++; $display("FAIL rst_ex_rd: got %0d want 0", ex_rd); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL rst_stall_count: got %0d want 0", stall_count); end
        n_checks++; if (ex_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %0h want 0", ex_illegal); end
        n_checks++; if (RS2 !== 5'd7) begin n_fail++; $display("FAIL rst_rs2_comb: got %0d want 7", RS2); end
        reset = 1'b1;
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL rst_release_capture: got %0h want 1", ex_valid); end
        n_checks++; if (ex_rd !== 5'd5) begin n_fail++; $display("FAIL rst_release_rd: got %0d want 5", ex_rd); end
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h00700293, 64'h10, 64'h0, 64'h77);
        n_checks++; if (RS1 !== 5'd0) begin n_fail++; $display("FAIL addi_rs1_comb: got %0d want 0", RS1); end
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL addi_id_ready: got %0h want 1", id_ready); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %0h want 1", ex_valid); end
        n_checks++; if (ex_rd !== 5'd5) begin n_fail++; $display("FAIL addi_rd: got %0d want 5", ex_rd); end
        n_checks++; if (ex_imm !== 64'd7) begin n_fail++; $display("FAIL addi_imm: got %0h want 7", ex_imm); end
        n_checks++; if (ex_RegWrite !== 1'b1) begin n_fail++; $display("FAIL addi_regwrite: got %0h want 1", ex_RegWrite); end
        n_checks++; if (ex_ALUSrc !== 1'b1) begin n_fail++; $display("FAIL addi_alusrc: got %0h want 1", ex_ALUSrc); end
        n_checks++; if (ex_ALUOp !== 2'b11) begin n_fail++; $display("FAIL addi_aluop: got %0b want 11", ex_ALUOp); end
        n_checks++; if (ex_MemRead !== 1'b0) begin n_fail++; $display("FAIL addi_memread: got %0h want 0", ex_MemRead); end
        n_checks++; if (ex_pc !== 64'h10) begin n_fail++; $display("FAIL addi_pc: got %0h want 10", ex_pc); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0002B303, 64'h100, 64'h1000, 64'h0);
        tick();
        n_checks++; if (ex_MemRead !== 1'b1) begin n_fail++; $display("FAIL ld_memread: got %0h want 1", ex_MemRead); end
        n_checks++; if (ex_MemtoReg !== 1'b1) begin n_fail++; $display("FAIL ld_memtoreg: got %0h want 1", ex_MemtoReg); end
        n_checks++; if (ex_rd !== 5'd6) begin n_fail++; $display("FAIL ld_rd: got %0d want 6", ex_rd); end
        n_checks++; if (ex_ALUOp !== 2'b00) begin n_fail++; $display("FAIL ld_aluop: got %0b want 00", ex_ALUOp); end
        drive(1'b1, 32'h006303B3, 64'h104, 64'hAAAA, 64'hBBBB);
        n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL lu_id_ready_low: got %0h want 0", id_ready); end
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %0h want 0", ex_valid); end
        n_checks++; if (ex_MemRead !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_ctrl: got %0h want 0", ex_MemRead); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL lu_stall_count: got %0d want 1", stall_count); end
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL lu_id_ready_back: got %0h want 1", id_ready); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0h want 1", ex_valid); end
        n_checks++; if (ex_pc !== 64'h104) begin n_fail++; $display("FAIL add_pc: got %0h want 104", ex_pc); end
        n_checks++; if (ex_rd !== 5'd7) begin n_fail++; $display("FAIL add_rd: got %0d want 7", ex_rd); end
        n_checks++; if (ex_rs2 !== 5'd6) begin n_fail++; $display("FAIL add_rs2: got %0d want 6", ex_rs2); end
        n_checks++; if (ex_ALUOp !== 2'b10) begin n_fail++; $display("FAIL add_aluop: got %0b want 10", ex_ALUOp); end
        n_checks++; if (ex_ALUSrc !== 1'b0) begin n_fail++; $display("FAIL add_alusrc: got %0h want 0", ex_ALUSrc); end
        n_checks++; if (ex_rs2_data !== 64'hBBBB) begin n_fail++; $display("FAIL add_rs2_data: got %0h want bbbb", ex_rs2_data); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL add_stall_count: got %0d want 1", stall_count); end
    endtask

    task automatic test_x0_load();
        drive(1'b1, 32'h0002B003, 64'h200, 64'h1000, 64'h0);
        tick();
        n_checks++; if (ex_RegWrite !== 1'b0) begin n_fail++; $display("FAIL ldx0_regwrite: got %0h want 0", ex_RegWrite); end
        n_checks++; if (ex_MemRead !== 1'b1) begin n_fail++; $display("FAIL ldx0_memread: got %0h want 1", ex_MemRead); end
        drive(1'b1, 32'h000003B3, 64'h204, 64'h0, 64'h0);
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL ldx0_no_stall: got %0h want 1", id_ready); end
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL ldx0_add_valid: got %0h want 1", ex_valid); end
        n_checks++; if (stall_count !== 32'd1) begin n_fail++; $display("FAIL ldx0_stall_count: got %0d want 1", stall_count); end
    endtask

    task automatic test_branch_store();
        drive(1'b1, 32'hFE208CE3, 64'h300, 64'h1, 64'h2);
        tick();
        n_checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL beq_imm: got %0h want fffffffffffffff8", ex_imm); end
        n_checks++; if (ex_Branch !== 1'b1) begin n_fail++; $display("FAIL beq_branch: got %0h want 1", ex_Branch); end
        n_checks++; if (ex_ALUOp !== 2'b01) begin n_fail++; $display("FAIL beq_aluop: got %0b want 01", ex_ALUOp); end
        n_checks++; if (ex_rs2 !== 5'd2) begin n_fail++; $display("FAIL beq_rs2: got %0d want 2", ex_rs2); end
        n_checks++; if (ex_rs1 !== 5'd1) begin n_fail++; $display("FAIL beq_rs1: got %0d want 1", ex_rs1); end
        n_checks++; if (ex_RegWrite !== 1'b0) begin n_fail++; $display("FAIL beq_regwrite: got %0h want 0", ex_RegWrite); end
        n_checks++; if (ex_funct !== 4'b1000) begin n_fail++; $display("FAIL beq_funct: got %0b want 1000", ex_funct); end
        drive(1'b1, 32'hFE50BE23, 64'h304, 64'h0, 64'h0);
        tick();
        n_checks++; if (ex_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL sd_imm: got %0h want fffffffffffffffc", ex_imm); end
        n_checks++; if (ex_MemWrite !== 1'b1) begin n_fail++; $display("FAIL sd_memwrite: got %0h want 1", ex_MemWrite); end
        n_checks++; if (ex_funct !== 4'b1011) begin n_fail++; $display("FAIL sd_funct: got %0b want 1011", ex_funct); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 32'h00700293, 64'h400, 64'h0, 64'h0);
        tick();
        ex_stall = 1'b1;
        drive(1'b1, 32'h006303B3, 64'h404, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL stall_id_ready[%0d]: got %0h want 0", i, id_ready); end
            tick();
            n_checks++; if (ex_pc !== 64'h400) begin n_fail++; $display("FAIL stall_hold_pc[%0d]: got %0h want 400", i, ex_pc); end
            n_checks++; if (ex_imm !== 64'd7) begin n_fail++; $display("FAIL stall_hold_imm[%0d]: got %0h want 7", i, ex_imm); end
        end
        ex_flush = 1'b1;
        #1;
        n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_id_ready: got %0h want 1", id_ready); end
        tick();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", ex_valid); end
        n_checks++; if (ex_pc !== 64'h0) begin n_fail++; $display("FAIL flush_pc: got %0h want 0", ex_pc); end
        n_checks++; if (ex_RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite: got %0h want 0", ex_RegWrite); end
        ex_stall = 1'b0; ex_flush = 1'b0;
        drive(1'b1, 32'h00000000, 64'h500, 64'h0, 64'h0);
        tick();
        n_checks++; if (ex_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %0h want 1", ex_illegal); end
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_valid: got %0h want 0", ex_valid); end
        drive(1'b0, 32'h00700293, 64'h504, 64'h0, 64'h0);
        tick();
        n_checks++; if (ex_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %0h want 0", ex_illegal); end
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL idle_bubble: got %0h want 0", ex_valid); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h00700293, 64'h600, 64'h0, 64'h0);
        tick();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pre_areset_valid: got %0h want 1", ex_valid); end
        reset = 1'b0;
        #1;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0h want 0", ex_valid); end
        n_checks++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL areset_stall_count: got %0d want 0", stall_count); end
        n_checks++; if (ex_pc !== 64'h0) begin n_fail++; $display("FAIL areset_pc: got %0h want 0", ex_pc); end
        #1;
        reset = 1'b1;
        tick();
        n_checks++; if (ex_pc !== 64'h600) begin n_fail++; $display("FAIL areset_release_pc: got %0h want 600", ex_pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_x0_load();
        test_branch_store();
        test_stall_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction-decode and issue stage of the 5-stage RV64 pipeline.
- Sits between the IF/ID register and the EX stage.
- Combinationally drives RS1/RS2 to the register file and decodes control and immediate from the instruction.
- Detects load-use hazards, then registers operands, immediate and control into the ID/EX pipeline register with stall and flush handling.

Parameters:
- XLEN, 64, datapath and register width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock, posedge.
- reset  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  instruction PC.
- id_ready  out  1  ID consumes the instruction this cycle; 0 tells fetch to hold.
- RS1, RS2  out  REG_ADDR_W  register file read addresses, combinational from if_instr.
- ReadData1, ReadData2  in  XLEN  register file read data, same cycle.
- ex_stall  in  1  EX cannot accept; hold ID/EX.
- ex_flush  in  1  taken branch; kill the ID/EX contents being loaded.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered operands and immediate.
- ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices, for the forwarding unit.
- ex_funct  out  4  {instr[30], instr[14:12]}.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_MemtoReg, ex_Branch  out  1  registered control.
- ex_ALUOp  out  2  00 load/store, 01 branch, 10 R-type, 11 I-ALU.
- ex_illegal  out  1  one-cycle pulse: unsupported opcode dropped.
- stall_count  out  32  load-use bubble counter, saturating.

Behaviour:
- Reset (asynchronous, reset low): every ex_* output, ex_illegal and stall_count go to 0 immediately. RS1/RS2 stay combinational.
- Decode fields: RS1=instr[19:15], RS2=instr[24:20], rd=instr[11:7].
- Supported opcodes:
  - R 0110011: RegWrite, ALUOp 10.
  - I-ALU 0010011: RegWrite, ALUSrc, ALUOp 11.
  - Load 0000011: RegWrite, MemRead, MemtoReg, ALUSrc, ALUOp 00.
  - Store 0100011: MemWrite, ALUSrc, ALUOp 00.
  - Branch 1100011: Branch, ALUOp 01.
  - Anything else is illegal.
- RegWrite is forced to 0 when rd==0.
- Immediates, all sign-extended to XLEN from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - R: 0.
- uses_rs1 is set for all five classes. uses_rs2 is set for R, S and B only.
- load_use = ex_valid & ex_MemRead & ex_rd!=0 & if_valid & ((uses_rs1 & ex_rd==RS1) | (uses_rs2 & ex_rd==RS2)).
- id_ready = ex_flush | (!ex_stall & !load_use).
- Posedge priority:
  1. ex_flush: load a bubble, even if ex_stall is high.
  2. ex_stall: hold all ID/EX registers.
  3. load_use: load a bubble; stall_count += 1, saturating at 0xFFFF_FFFF.
  4. if_valid & legal: capture decode, ReadData1/2, if_pc; ex_valid=1.
  5. if_valid & illegal: load a bubble; ex_illegal=1 for that cycle.
  6. Otherwise: load a bubble.
- Bubble definition: ex_valid=0 and all control fields 0; data fields zeroed.
- ex_illegal clears on the next edge unless asserted again.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble.
- Writeback needs no bypass: the register file writes on negedge and reads combinationally.
- Reset deasserting mid-stream: the first edge after release behaves as a normal edge.

Decomposition:
- Shared package:
  - XLEN and REG_ADDR_W defaults.
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - ALUOp encodings.
- One sub-module, imm_gen: purely combinational, takes instr[31:0] and produces the XLEN-wide sign-extended immediate.
- Hazard logic and the control table stay inline.

Test Plan:
1. reset low with if_valid=1 and instr 0x00700293 → all ex_* 0 and stall_count 0 while reset is low. After release, the next edge captures the instruction.
2. addi x5,x0,7 (0x00700293) → next cycle:
   - ex_valid=1, ex_rd=5, ex_imm=7, ex_RegWrite=1, ex_ALUSrc=1, ex_ALUOp=11.
   - RS1=0 driven combinationally before the edge.
3. ld x6,0(x5) (0x0002B303) followed by add x7,x6,x6 (0x00630333 with rd=7, i.e. 0x006303B3):
   - id_ready=0 for one cycle, ex_valid=0 bubble, stall_count=1.
   - The add is captured on the following edge.
4. ld x0,0(x5) followed by add x7,x0,x0 → no stall, stall_count unchanged. The load has ex_RegWrite=0.
5. beq x1,x2,-8 (0xFE208CE3) → ex_imm=0xFFFF_FFFF_FFFF_FFF8, ex_Branch=1, ex_ALUOp=01, ex_rs2=2.
6. ex_stall held 3 cycles → ID/EX values frozen and id_ready=0. Then ex_stall=1 and ex_flush=1 together → ex_valid=0 and id_ready=1. Then instr 0x00000000 → ex_illegal pulse for one cycle, ex_valid=0.
